// File: rtl/seq_ctrl_pkg.sv
// Shared types and constants for the group-framed sequence detector controller.
package seq_ctrl_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } st_e;

  localparam logic [7:0] RST_PATTERN = 8'h1C;
  localparam int         RST_LEN     = 6;

  // Zero and out-of-range lengths both select the full group width.
  function automatic int clamp_len(input int len, input int max_len);
    if (len == 0 || len > max_len) return max_len;
    return len;
  endfunction

endpackage

// File: rtl/seq_group_ctrl_if.sv
// Configuration, control, serial-data and status bundle for seq_group_ctrl.
// Inputs are sampled on the rising clock edge; no back-pressure exists, so a
// bit with data_valid=1 seen in RUN is always consumed on that edge.
interface seq_group_ctrl_if
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               cfg_we;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               start;
  logic               stop;
  logic               data_valid;
  logic               data;
  logic               busy;
  logic               match;
  logic               not_match;
  logic [CNT_W-1:0]   group_cnt;
  logic [CNT_W-1:0]   match_cnt;
  st_e                state_dbg;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, start, stop, data_valid, data,
    input  busy, match, not_match, group_cnt, match_cnt, state_dbg
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, start, stop, data_valid, data,
    output busy, match, not_match, group_cnt, match_cnt, state_dbg
  );
endinterface

// File: rtl/seq_group_shift.sv
// Group assembly: shift register, bit counter and masked pattern comparator.
module seq_group_shift #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               bit_en,
  input  logic               data,
  input  logic [LEN_W-1:0]   len,
  input  logic [MAX_LEN-1:0] pattern,
  output logic               group_done,
  output logic               group_eq
);
  logic [MAX_LEN-1:0] shift_q, shift_d, mask;
  logic [LEN_W-1:0]   bit_cnt;

  // The comparison uses the vector including the bit arriving this cycle.
  always_comb begin
    shift_d = shift_q;
    mask    = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (bit_cnt == LEN_W'(i)) shift_d[i] = data;
      if (i < int'(len))        mask[i]    = 1'b1;
    end
  end

  assign group_done = bit_en && (bit_cnt == len - LEN_W'(1));
  assign group_eq   = ~|((shift_d ^ pattern) & mask);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (clear) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else if (bit_en) begin
      shift_q <= shift_d;
      bit_cnt <= group_done ? '0 : bit_cnt + LEN_W'(1);
    end
  end
endmodule

// File: rtl/seq_group_ctrl.sv
// Run sequencing, configuration, result pulses and optional statistics.
// Statistics counters are built only when SEQ_CTRL_CNT_EN is defined.
module seq_group_ctrl
  import seq_ctrl_pkg::*;
#(
  parameter int MAX_LEN = 8,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             rst_n,
  seq_group_ctrl_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(RST_PATTERN);
  localparam logic [LEN_W-1:0]   RST_L   = LEN_W'(clamp_len(RST_LEN, MAX_LEN));

  st_e                state_q, state_d;
  logic               run_start;
  logic               bit_en;
  logic               group_done, group_eq;
  logic [MAX_LEN-1:0] pattern_q;
  logic [LEN_W-1:0]   len_q;
  logic               match_q, not_match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    run_start = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.start) begin
        state_d   = ST_RUN;
        run_start = 1'b1;
      end
      ST_RUN:  if (bus.stop) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // A write in the start cycle lands before the first bit is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_q <= RST_PAT;
      len_q     <= RST_L;
    end else if (state_q == ST_IDLE && bus.cfg_we) begin
      pattern_q <= bus.cfg_pattern;
      len_q     <= LEN_W'(clamp_len(int'(bus.cfg_len), MAX_LEN));
    end
  end

  assign bit_en = (state_q == ST_RUN) && bus.data_valid;

  seq_group_shift #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) u_shift (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (run_start),
    .bit_en     (bit_en),
    .data       (bus.data),
    .len        (len_q),
    .pattern    (pattern_q),
    .group_done (group_done),
    .group_eq   (group_eq)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q     <= 1'b0;
      not_match_q <= 1'b0;
    end else begin
      match_q     <= group_done && group_eq;
      not_match_q <= group_done && !group_eq;
    end
  end

`ifdef SEQ_CTRL_CNT_EN
  logic [CNT_W-1:0] group_cnt_q, match_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      group_cnt_q <= '0;
      match_cnt_q <= '0;
    end else if (run_start) begin
      group_cnt_q <= '0;
      match_cnt_q <= '0;
    end else if (group_done) begin
      if (group_cnt_q != '1)             group_cnt_q <= group_cnt_q + CNT_W'(1);
      if (group_eq && match_cnt_q != '1) match_cnt_q <= match_cnt_q + CNT_W'(1);
    end
  end

  assign bus.group_cnt = group_cnt_q;
  assign bus.match_cnt = match_cnt_q;
`else
  assign bus.group_cnt = '0;
  assign bus.match_cnt = '0;
`endif

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.match     = match_q;
  assign bus.not_match = not_match_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_seq_group_ctrl.sv
// Directed bench for seq_group_ctrl (MAX_LEN=8, CNT_W=2).
module tb_seq_group_ctrl;
  import seq_ctrl_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int CNT_W   = 2;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  seq_group_ctrl_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

  seq_group_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected counter value given the number of events seen this run
  function automatic logic [31:0] exp_cnt(input int n);
`ifdef SEQ_CTRL_CNT_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One cycle of stimulus; returns at the next falling edge so outputs
  // reflect the rising edge that sampled these inputs.
  task automatic step(input logic cw, input logic [LEN_W-1:0] len, input logic [MAX_LEN-1:0] pat,
                      input logic st, input logic sp, input logic v, input logic d);
    bus.cfg_we      = cw;
    bus.cfg_len     = len;
    bus.cfg_pattern = pat;
    bus.start       = st;
    bus.stop        = sp;
    bus.data_valid  = v;
    bus.data        = d;
    @(negedge clk);
    bus.cfg_we      = 1'b0;
    bus.start       = 1'b0;
    bus.stop        = 1'b0;
    bus.data_valid  = 1'b0;
    bus.data        = 1'($urandom_range(0, 1));
    check("excl", 32'(bus.match & bus.not_match), 32'd0);
  endtask

  task automatic bit_in(input logic d);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, d);
  endtask

  task automatic idle_cycle();
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
  endtask

  task automatic do_start();
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_stop();
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic check_pulse(input string tag, input logic m, input logic nm);
    check({tag, "_m"},  32'(bus.match),     32'(m));
    check({tag, "_nm"}, 32'(bus.not_match), 32'(nm));
  endtask

  task automatic check_cnt(input string tag, input int g, input int m);
    check({tag, "_gcnt"}, 32'(bus.group_cnt), exp_cnt(g));
    check({tag, "_mcnt"}, 32'(bus.match_cnt), exp_cnt(m));
  endtask

  // sends a group from a vector in received order (element 0 first)
  task automatic send_group(input string tag, input logic g[], input int gaps,
                            input logic m, input logic nm);
    for (int i = 0; i < g.size(); i++) begin
      bit_in(g[i]);
      if (i == g.size() - 1) check_pulse(tag, m, nm);
      else                   check_pulse({tag, "_mid"}, 1'b0, 1'b0);
      if (gaps != 0 && i != g.size() - 1)
        repeat ($urandom_range(0, gaps)) idle_cycle();
    end
  endtask

  logic g_match[]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic g_miss[]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic g_101[]    = '{1'b1, 1'b0, 1'b1};
  logic g_a5[]     = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
  logic g_a5_bad[] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  initial begin
    n_checks = 0;
    n_fail   = 0;
    bus.cfg_we = 1'b0; bus.cfg_len = '0; bus.cfg_pattern = '0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.data_valid = 1'b0; bus.data = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check_pulse("rst", 1'b0, 1'b0);
    check_cnt("rst", 0, 0);

    // default pattern 0,0,1,1,1,0 then a mismatching group, with and without gaps
    do_start();
    check("start_busy", 32'(bus.busy), 32'd1);
    send_group("g1", g_match, 0, 1'b1, 1'b0);
    check_cnt("g1", 1, 1);
    send_group("g2", g_miss, 0, 1'b0, 1'b1);
    check_cnt("g2", 2, 1);
    idle_cycle();
    check_pulse("g2_after", 1'b0, 1'b0);
    send_group("g3gap", g_miss, 3, 1'b0, 1'b1);
    check_cnt("g3gap", 3, 1);
    send_group("g4gap", g_match, 3, 1'b1, 1'b0);
    do_stop();
    check("stop_busy", 32'(bus.busy), 32'd0);

    // config in the start cycle applies to the run; writes during RUN ignored
    step(1'b1, 4'd3, 8'b0000_0101, 1'b1, 1'b0, 1'b0, 1'b0);
    check("cfgst_busy", 32'(bus.busy), 32'd1);
    check_cnt("cfgst", 0, 0);
    step(1'b1, 4'd3, 8'b0000_0010, 1'b0, 1'b0, 1'b1, 1'b1);
    check_pulse("c1_b0", 1'b0, 1'b0);
    bit_in(1'b0);
    bit_in(1'b1);
    check_pulse("c1", 1'b1, 1'b0);
    send_group("c2", g_101, 0, 1'b1, 1'b0);
    check_cnt("c2", 2, 2);
    do_stop();

    // stop mid-group discards; stop with final bit still reports
    step(1'b1, 4'd6, 8'h1C, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start();
    bit_in(1'b0); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1);
    do_stop();
    check_pulse("stop4", 1'b0, 1'b0);
    check("stop4_busy", 32'(bus.busy), 32'd0);
    idle_cycle();
    check_pulse("stop4_after", 1'b0, 1'b0);
    do_start();
    bit_in(1'b0); bit_in(1'b0); bit_in(1'b1); bit_in(1'b1); bit_in(1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_pulse("stop6", 1'b1, 1'b0);
    check("stop6_busy", 32'(bus.busy), 32'd0);
    check_cnt("stop6", 1, 1);

    // saturation: five matching groups back to back
    do_start();
    for (int k = 0; k < 5; k++) begin
      send_group("sat", g_match, 0, 1'b1, 1'b0);
      check_cnt("sat", k + 1, k + 1);
    end
    do_stop();
    repeat (3) idle_cycle();
    check_cnt("sat_hold", 5, 5);
    do_start();
    check_cnt("sat_clr", 0, 0);
    do_stop();

    // length clamp: 0 and MAX_LEN+3 both mean MAX_LEN
    step(1'b1, 4'd0, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);
    do_start();
    send_group("len0", g_a5, 0, 1'b1, 1'b0);
    do_stop();
    step(1'b1, 4'(MAX_LEN + 3), 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    send_group("len11", g_a5_bad, 0, 1'b0, 1'b1);
    send_group("len11b", g_a5, 0, 1'b1, 1'b0);
    do_stop();

    // length 1: one pulse per valid bit, no dead cycle
    step(1'b1, 4'd1, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1); check_pulse("l1a", 1'b1, 1'b0);
    bit_in(1'b0); check_pulse("l1b", 1'b0, 1'b1);
    bit_in(1'b1); check_pulse("l1c", 1'b1, 1'b0);
    check_cnt("l1", 3, 2);
    do_stop();

    // asynchronous reset mid-group restores defaults
    step(1'b1, 4'd3, 8'h05, 1'b1, 1'b0, 1'b0, 1'b0);
    bit_in(1'b1);
    bit_in(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_state", 32'(bus.state_dbg), 32'(ST_IDLE));
    check_pulse("arst", 1'b0, 1'b0);
    check_cnt("arst", 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_start();
    send_group("post_rst", g_match, 0, 1'b1, 1'b0);
    do_stop();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
